// File: rtl/irq_pkg.sv
// Shared types and limits for the external interrupt arbiter.
package irq_pkg;

    localparam int NSRC_MAX = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational selector: the first set bit of elig at or after start, wrapping modulo NSRC.
module irq_prio_sel
    import irq_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] elig,
    input  logic [IDW-1:0]  start,
    output logic [IDW-1:0]  idx,
    output logic            valid
);

    logic [2*NSRC-1:0] dbl;
    logic [NSRC-1:0]   rot;
    int                pos;

    // Rotate so that bit 0 of rot corresponds to elig[start].
    assign dbl = {elig, elig} >> start;
    assign rot = dbl[NSRC-1:0];

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int k = 0; k < NSRC; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                pos   = int'(start) + k;
                if (pos >= NSRC) pos = pos - NSRC;
                idx   = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Edge-latching interrupt arbiter feeding the controller's ExtIRQ/ExtIAck/ERet handshake.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; the default is fixed lowest-index priority.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic [NSRC-1:0] irq_mask,
    input  logic            ExtIAck,
    input  logic            ERet,
    output logic            ExtIRQ,
    output logic [IDW-1:0]  irq_id,
    output logic            in_service,
    output logic [NSRC-1:0] pending
);

    irq_state_t      state;
    logic [NSRC-1:0] prev_irq;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] elig;
    logic [IDW-1:0]  start;
    logic [IDW-1:0]  sel_idx;
    logic            sel_valid;
    logic            ack_hit;

    assign rise    = irq_in & ~prev_irq;
    assign ack_hit = (state == REQ) && ExtIAck;
    assign clr     = ack_hit ? (NSRC'(1) << irq_id) : '0;
    assign elig    = pending & irq_mask;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_ptr;
    int             rr_next;

    assign rr_next = (int'(irq_id) + 1) % NSRC;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (ack_hit) begin
            rr_ptr <= IDW'(rr_next);
        end
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    irq_prio_sel #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_sel (
        .elig  (elig),
        .start (start),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev_irq   <= '0;
            pending    <= '0;
            ExtIRQ     <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
        end else begin
            prev_irq <= irq_in;
            // A new edge on the bit being acknowledged survives the clear.
            pending  <= (pending & ~clr) | (rise & irq_mask);

            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        irq_id <= sel_idx;
                        ExtIRQ <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (ExtIAck) begin
                        ExtIRQ     <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (ERet) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    ExtIRQ     <= 1'b0;
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
